// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM state encoding
// and default geometry (psum width, columns per beat, positions per tile).
package psum_acc_pkg;

  localparam int unsigned PSUM_BW_DEF = 16;
  localparam int unsigned COL_DEF     = 8;
  localparam int unsigned DEPTH_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/psum_acc_sat_add.sv
// Signed saturating adder for one column.
//   a     : stored partial sum
//   b     : incoming partial sum
//   ovw   : 1 -> pass b through unchanged (first tile), 0 -> a + b clamped
//   sum_c : combinational result
module sat_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ovw,
  output logic [W-1:0] sum_c
);

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] ext_c;

  assign ext_c = {a[W-1], a} + {b[W-1], b};

  // Overflow shows as disagreement between the two top bits of the extended sum.
  always_comb begin
    sum_c = ext_c[W-1:0];
    if (ovw) begin
      sum_c = b;
    end else if (ext_c[W] != ext_c[W-1]) begin
      sum_c = ext_c[W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/psum_acc.sv
// Accumulates num_tiles tiles of DEPTH beats of COL signed partial sums
// into a local buffer, then drains ReLU'd results with valid/ready.
//   clk, reset (async, active-low)
//   start, num_tiles      : begin a pass (IDLE only), tile count (0 -> 1)
//   in_valid/in_ready     : input beat handshake, in_data packed per column
//   out_valid/out_ready   : output handshake, out_data packed per column
//   busy                  : not IDLE
//   done                  : one-cycle pulse at pass completion
module psum_acc
  import psum_acc_pkg::*;
#(
  parameter int unsigned PSUM_BW = PSUM_BW_DEF,
  parameter int unsigned COL     = COL_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_tiles,
  input  logic                   in_valid,
  input  logic [COL*PSUM_BW-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [COL*PSUM_BW-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DW    = COL * PSUM_BW;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  state_e           state, state_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [3:0]       tile_cnt, tile_cnt_n, tiles, tiles_n;
  logic             in_ready_n, out_valid_n, busy_n, done_n;
  logic [DW-1:0]    out_data_n;
  logic [DW-1:0]    old_word_c, new_word_c, rd_word_c;
  logic             accept_c;

  // Result buffer; deliberately not reset, the first tile overwrites it.
  logic [DW-1:0]    mem [DEPTH];

  assign accept_c   = (state == ACC) && in_valid && in_ready;
  assign old_word_c = mem[wr_ptr];
  assign rd_word_c  = mem[rd_ptr_n];

  // One saturating adder per column; first tile of a pass overwrites.
  for (genvar c = 0; c < COL; c++) begin : g_col
    localparam int unsigned LO = c * PSUM_BW;

    sat_add #(.W(PSUM_BW)) u_sat_add (
      .a     (old_word_c[LO +: PSUM_BW]),
      .b     (in_data[LO +: PSUM_BW]),
      .ovw   (tile_cnt == 4'd0),
      .sum_c (new_word_c[LO +: PSUM_BW])
    );

    // ReLU on the word addressed by the next read pointer.
    assign out_data_n[LO +: PSUM_BW] =
      rd_word_c[LO + PSUM_BW - 1] ? '0 : rd_word_c[LO +: PSUM_BW];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    tile_cnt_n = tile_cnt;
    tiles_n    = tiles;

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = ACC;
          tiles_n    = (num_tiles == 4'd0) ? 4'd1 : num_tiles;
          wr_ptr_n   = '0;
          rd_ptr_n   = '0;
          tile_cnt_n = '0;
        end
      end
      ACC: begin
        if (accept_c) begin
          wr_ptr_n = wr_ptr + PTR_W'(1);
          if (wr_ptr == LAST) begin
            wr_ptr_n   = '0;
            tile_cnt_n = tile_cnt + 4'd1;
            if (({1'b0, tile_cnt} + 5'd1) == {1'b0, tiles}) begin
              state_n = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          rd_ptr_n = rd_ptr + PTR_W'(1);
          if (rd_ptr == LAST) begin
            rd_ptr_n = '0;
            state_n  = FIN;
          end
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    in_ready_n  = (state_n == ACC);
    out_valid_n = (state_n == DRAIN);
    done_n      = (state_n == FIN);
    busy_n      = (state_n != IDLE);
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tile_cnt  <= '0;
      tiles     <= 4'd1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      tile_cnt  <= tile_cnt_n;
      tiles     <= tiles_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      done      <= done_n;
      busy      <= busy_n;
      out_data  <= out_data_n;
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= new_word_c;
    end
  end

endmodule

// File: tb/tb_psum_acc.sv
// Self-checking bench for psum_acc against a tile-accumulation reference model.
module tb_psum_acc;

  localparam int W = 16;
  localparam int C = 8;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [3:0]     num_tiles;
  logic           in_valid;
  logic [C*W-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic [C*W-1:0] out_data;
  logic           out_ready;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  psum_acc #(.PSUM_BW(W), .COL(C), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_tiles (num_tiles),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;

  int stim    [16][D][C];
  int got     [D][C];
  int ref_got [D][C];
  int exp_v   [D][C];
  bit timed_out, hold_bad;
  int stall_hits, done_cnt;

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  // Reference: first tile sets the value, later tiles add with clamping, then ReLU.
  task automatic build_model(input int nt);
    for (int k = 0; k < D; k++) begin
      for (int c = 0; c < C; c++) begin
        int acc;
        acc = stim[0][k][c];
        for (int t = 1; t < nt; t++) acc = clamp16(acc + stim[t][k][c]);
        exp_v[k][c] = (acc < 0) ? 0 : acc;
      end
    end
  endtask

  task automatic drive_beat(input int t, input int k);
    for (int c = 0; c < C; c++) in_data[c*W +: W] = 16'(stim[t][k][c]);
  endtask

  // Runs one full pass, collecting drained words into got[].
  task automatic run_pass(input logic [3:0] nt, input int n_eff, input int gap_pct,
                          input int stall_at, input bit poke_start);
    int guard;
    logic [C*W-1:0] snap;
    timed_out = 0; hold_bad = 0; stall_hits = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; num_tiles = nt;
    @(posedge clk); #1;
    start = 1'b0; num_tiles = 4'($urandom);
    for (int t = 0; t < n_eff; t++) begin
      for (int k = 0; k < D; k++) begin
        while ($urandom_range(99) < 32'(gap_pct)) begin
          in_valid = 1'b0; @(posedge clk); #1;
        end
        drive_beat(t, k);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (guard >= 200) timed_out = 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    for (int k = 0; k < D; k++) begin
      guard = 0;
      while (!out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
      if (guard >= 200) timed_out = 1;
      if (k == stall_at) begin
        out_ready = 1'b0;
        snap = out_data;
        repeat (5) begin
          @(posedge clk); #1;
          stall_hits++;
          if (out_data !== snap || out_valid !== 1'b1) hold_bad = 1;
        end
      end
      while ($urandom_range(99) < 32'(gap_pct)) begin
        out_ready = 1'b0; @(posedge clk); #1;
      end
      if (poke_start && k == 2) begin start = 1'b1; num_tiles = 4'd9; end
      out_ready = 1'b1;
      for (int c = 0; c < C; c++) got[k][c] = int'($signed(out_data[c*W +: W]));
      @(posedge clk); #1;
      out_ready = 1'b0; start = 1'b0;
    end
    repeat (4) begin
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; num_tiles = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL idle_outputs in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid); end
  endtask

  task automatic test_single_tile();
    for (int k = 0; k < D; k++) begin
      stim[0][k][0] = k;
      for (int c = 1; c < C; c++) stim[0][k][c] = rnd16();
    end
    build_model(1);
    run_pass(4'd1, 1, 0, -1, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
    for (int k = 0; k < D; k++) begin
      checks++;
      if (got[k][0] !== k) begin failures++; $display("FAIL single_col0 k=%0d got=%0d exp=%0d", k, got[k][0], k); end
      for (int c = 1; c < C; c++)
        if (got[k][c] !== exp_v[k][c]) begin
          checks++; failures++;
          $display("FAIL single_col k=%0d c=%0d got=%0d exp=%0d", k, c, got[k][c], exp_v[k][c]);
        end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_multi_tile();
    for (int t = 0; t < 3; t++) for (int k = 0; k < D; k++) for (int c = 0; c < C; c++) stim[t][k][c] = 5;
    run_pass(4'd3, 3, 0, -1, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL multi_timeout got=1 exp=0"); end
    for (int k = 0; k < D; k++) begin
      checks++;
      for (int c = 0; c < C; c++)
        if (got[k][c] !== 15) begin
          failures++; $display("FAIL multi_value k=%0d c=%0d got=%0d exp=15", k, c, got[k][c]);
          break;
        end
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 2; t++) for (int k = 0; k < D; k++) for (int c = 0; c < C; c++)
      stim[t][k][c] = (c % 2 == 0) ? 28672 : -28672;
    run_pass(4'd2, 2, 0, -1, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL sat_timeout got=1 exp=0"); end
    for (int k = 0; k < D; k++) begin
      checks++;
      for (int c = 0; c < C; c++) begin
        int e;
        e = (c % 2 == 0) ? 32767 : 0;
        if (got[k][c] !== e) begin
          failures++; $display("FAIL sat_relu k=%0d c=%0d got=%0d exp=%0d", k, c, got[k][c], e);
          break;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) for (int k = 0; k < D; k++) for (int c = 0; c < C; c++) stim[t][k][c] = rnd16();
    build_model(2);
    run_pass(4'd2, 2, 0, -1, 0);
    ref_got = got;
    run_pass(4'd2, 2, 35, 3, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (hold_bad || stall_hits != 5)
      begin failures++; $display("FAIL bp_hold held_bad=%0d stall_cycles=%0d exp=0/5", hold_bad, stall_hits); end
    for (int k = 0; k < D; k++) begin
      checks++;
      for (int c = 0; c < C; c++)
        if (got[k][c] !== ref_got[k][c] || got[k][c] !== exp_v[k][c]) begin
          failures++;
          $display("FAIL bp_data k=%0d c=%0d got=%0d nostall=%0d exp=%0d", k, c, got[k][c], ref_got[k][c], exp_v[k][c]);
          break;
        end
    end
  endtask

  task automatic test_reset_mid();
    int new_vals [D][C];
    @(posedge clk); #1;
    start = 1'b1; num_tiles = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < D + 7; n++) begin
      in_data = {C{16'(100 + n)}};
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL midreset_async busy=%b in_ready=%b out_valid=%b done=%b exp=0", busy, in_ready, out_valid, done); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    for (int k = 0; k < D; k++) for (int c = 0; c < C; c++) begin
      new_vals[k][c] = rnd16();
      stim[0][k][c] = new_vals[k][c];
    end
    build_model(1);
    run_pass(4'd1, 1, 10, -1, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL midreset_timeout got=1 exp=0"); end
    for (int k = 0; k < D; k++) begin
      checks++;
      for (int c = 0; c < C; c++)
        if (got[k][c] !== exp_v[k][c]) begin
          failures++; $display("FAIL midreset_data k=%0d c=%0d got=%0d exp=%0d", k, c, got[k][c], exp_v[k][c]);
          break;
        end
    end
  endtask

  task automatic test_start_busy();
    for (int t = 0; t < 2; t++) for (int k = 0; k < D; k++) for (int c = 0; c < C; c++)
      stim[t][k][c] = int'($urandom_range(0, 3000)) - 1000;
    build_model(2);
    run_pass(4'd2, 2, 0, -1, 1);
    checks++; if (timed_out) begin failures++; $display("FAIL startbusy_timeout got=1 exp=0"); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL startbusy_done got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startbusy_idle got=%b exp=0", busy); end
    for (int k = 0; k < D; k++) begin
      checks++;
      for (int c = 0; c < C; c++)
        if (got[k][c] !== exp_v[k][c]) begin
          failures++; $display("FAIL startbusy_data k=%0d c=%0d got=%0d exp=%0d", k, c, got[k][c], exp_v[k][c]);
          break;
        end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      logic [3:0] nt;
      int ne;
      nt = (p == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      ne = (nt == 4'd0) ? 1 : int'(nt);
      for (int t = 0; t < ne; t++) for (int k = 0; k < D; k++) for (int c = 0; c < C; c++) stim[t][k][c] = rnd16();
      build_model(ne);
      run_pass(nt, ne, 20, int'($urandom_range(0, D - 1)), 0);
      checks++; if (timed_out || hold_bad || done_cnt != 1)
        begin failures++; $display("FAIL rand_ctrl pass=%0d timeout=%0d hold_bad=%0d done=%0d exp=0/0/1", p, timed_out, hold_bad, done_cnt); end
      for (int k = 0; k < D; k++) begin
        checks++;
        for (int c = 0; c < C; c++)
          if (got[k][c] !== exp_v[k][c]) begin
            failures++; $display("FAIL rand_data pass=%0d k=%0d c=%0d got=%0d exp=%0d", p, k, c, got[k][c], exp_v[k][c]);
            break;
          end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
